water_tank_level_scanner: RTL and testbench

- Parametrised, scanned LED-matrix renderer for the water-tank level icon, replacing the fixed per-column combinational image decoders.
- Draws the tank (walls, floor, water column) on a ROWS x COLS matrix and multiplexes one column at a time.
- Animates the displayed level one step at a time toward the measured level, and blinks the tank when empty.
- Sits between the level-sensor logic and the LED matrix column/row drivers.

---
 rtl/water_tank_level_scanner_pkg.sv | 64 ++++++
 rtl/water_tank_level_scanner_tick_divider.sv | 55 +++++
 rtl/water_tank_level_scanner.sv | 179 +++++++++++++++++
 tb/tb_water_tank_level_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/water_tank_level_scanner_pkg.sv
// ----------------------------------------------------------------------------
// water_tank_pkg
// Shared definitions for the water-tank level scanner:
//   - clog2 helper for counter widths
//   - max_level(): highest level code for a given level width
//   - water_rows(): number of water rows above the floor for a level
//   - column kind enum and the wall/floor pixel constants
//   - pixel_lit(): image of one pixel for a column kind and water height
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package water_tank_pkg;

  typedef enum logic [0:0] {
    COL_WALL     = 1'b0,
    COL_INTERIOR = 1'b1
  } col_kind_e;

  // Walls are drawn fully lit and the floor row is always lit.
  localparam logic WALL_PIXEL  = 1'b1;
  localparam logic FLOOR_PIXEL = 1'b1;
  localparam logic WATER_PIXEL = 1'b1;
  localparam logic EMPTY_PIXEL = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int max_level(input int level_w);
    return (32'sd1 <<< level_w) - 32'sd1;
  endfunction

  // Floor of level*(rows-1)/max_lvl. The 32-bit intermediate is wider than
  // level_w + clog2(rows) for every legal parameter set, so nothing truncates.
  function automatic int water_rows(input int level, input int rows, input int max_lvl);
    return (level * (rows - 32'sd1)) / max_lvl;
  endfunction

  function automatic logic pixel_lit(input col_kind_e kind, input int row,
                                     input int rows, input int water);
    logic lit;
    case (kind)
      COL_WALL: lit = WALL_PIXEL;
      COL_INTERIOR: begin
        if (row == rows - 32'sd1) begin
          lit = FLOOR_PIXEL;
        end else if (row >= rows - 32'sd1 - water) begin
          lit = WATER_PIXEL;
        end else begin
          lit = EMPTY_PIXEL;
        end
      end
      default: lit = EMPTY_PIXEL;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/water_tank_level_scanner_tick_divider.sv
// ----------------------------------------------------------------------------
// tick_divider
// Free-running modulo-DIV counter emitting a registered one-cycle tick while
// the count sits at DIV-1. clr_i synchronously parks the count at 0.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear of the count
//   tick_o  - high for one cycle out of every DIV
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tick_divider
  import water_tank_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and next tick; the tick is registered so it lines up with
  // the count reaching DIV-1.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Count and tick registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/water_tank_level_scanner.sv
// ----------------------------------------------------------------------------
// water_tank_level_scanner
// Scanned LED-matrix renderer for the water-tank icon. The measured level is
// synchronised, the displayed level walks one step at a time toward it, and
// the tank image (walls, floor, water column) is multiplexed one column at a
// time with a blank first slot per column. The tank blinks while empty.
// Ports:
//   clk               - system clock
//   reset_n           - asynchronous active-low reset
//   enable            - display enable; low blanks and parks the scan
//   tank_level_status - measured level, asynchronous to clk
//   column_select     - one-hot active-high column drive
//   rows_status       - active-high row drive for the selected column
//   level_displayed   - level currently drawn
//   empty_alarm       - high while displayed and measured level are both 0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module water_tank_level_scanner
  import water_tank_pkg::*;
#(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int LEVEL_W   = 2,
  parameter int SCAN_DIV  = 4,
  parameter int STEP_DIV  = 8,
  parameter int BLINK_DIV = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] tank_level_status,
  output logic [COLS-1:0]    column_select,
  output logic [ROWS-1:0]    rows_status,
  output logic [LEVEL_W-1:0] level_displayed,
  output logic               empty_alarm
);

  localparam int              MAX_LEVEL = max_level(LEVEL_W);
  localparam logic [COLS-1:0] COL0      = COLS'(1'b1);

  logic               scan_tick_s, step_tick_s, blink_tick_s;
  logic [LEVEL_W-1:0] sync1_q, target_q;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               alarm_q, alarm_d;
  logic               blink_q, blink_d;
  logic               blank_q, blank_d;
  logic [COLS-1:0]    col_q, col_d;
  logic [COLS-1:0]    col_sel_q, col_sel_d;
  logic [ROWS-1:0]    rows_q, rows_d;
  logic [ROWS-1:0]    image_s;
  col_kind_e          kind_s;
  int                 water_s;

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (~enable),
    .tick_o (scan_tick_s)
  );

  tick_divider #(.DIV(STEP_DIV)) u_step_div (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (1'b0),
    .tick_o (step_tick_s)
  );

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (1'b0),
    .tick_o (blink_tick_s)
  );

  // Two-flop synchroniser for the asynchronous level input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      target_q <= '0;
    end else begin
      sync1_q  <= tank_level_status;
      target_q <= sync1_q;
    end
  end

  // Animation step toward the registered target; equal means hold.
  always_comb begin
    if (!step_tick_s) begin
      level_d = level_q;
    end else if (level_q < target_q) begin
      level_d = level_q + LEVEL_W'(1'b1);
    end else if (level_q > target_q) begin
      level_d = level_q - LEVEL_W'(1'b1);
    end else begin
      level_d = level_q;
    end
  end

  // Empty alarm and blink phase.
  always_comb begin
    alarm_d = (level_q == '0) && (target_q == '0);
    if (blink_tick_s) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // Image of the column currently held in col_q at the displayed level.
  assign water_s = water_rows(int'(level_q), ROWS, MAX_LEVEL);

  // Column kind from the one-hot column position.
  always_comb begin
    if (col_q[0] || col_q[COLS-1]) begin
      kind_s = COL_WALL;
    end else begin
      kind_s = COL_INTERIOR;
    end
  end

  // Per-row pixel decode.
  always_comb begin
    image_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      image_s[r] = pixel_lit(kind_s, r, ROWS, water_s);
    end
  end

  // Scan position and output drive. blank_q marks slot 0 of a column: it is
  // set right after a slot wrap and whenever the scan is parked by enable=0.
  always_comb begin
    if (!enable) begin
      col_d     = COL0;
      blank_d   = 1'b1;
      col_sel_d = '0;
      rows_d    = '0;
    end else begin
      if (scan_tick_s) begin
        col_d = {col_q[COLS-2:0], col_q[COLS-1]};
      end else begin
        col_d = col_q;
      end
      blank_d   = scan_tick_s;
      col_sel_d = col_q;
      if (blank_q || (alarm_q && blink_q)) begin
        rows_d = '0;
      end else begin
        rows_d = image_s;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= '0;
      alarm_q   <= 1'b0;
      blink_q   <= 1'b0;
      blank_q   <= 1'b1;
      col_q     <= COL0;
      col_sel_q <= COL0;
      rows_q    <= '0;
    end else begin
      level_q   <= level_d;
      alarm_q   <= alarm_d;
      blink_q   <= blink_d;
      blank_q   <= blank_d;
      col_q     <= col_d;
      col_sel_q <= col_sel_d;
      rows_q    <= rows_d;
    end
  end

  assign column_select   = col_sel_q;
  assign rows_status     = rows_q;
  assign level_displayed = level_q;
  assign empty_alarm     = alarm_q;

endmodule

// File: tb/tb_water_tank_level_scanner.sv
`timescale 1ns/1ps
module tb_water_tank_level_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       enable, enable2;
  logic [1:0] tank;
  logic [4:0] cs;
  logic [6:0] rows;
  logic [1:0] lvl;
  logic       alarm;
  logic [2:0] tank2;
  logic [5:0] cs2;
  logic [7:0] rows2;
  logic [2:0] lvl2;
  logic       alarm2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  water_tank_level_scanner dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .tank_level_status(tank),
    .column_select(cs), .rows_status(rows), .level_displayed(lvl), .empty_alarm(alarm)
  );

  water_tank_level_scanner #(.ROWS(8), .COLS(6), .LEVEL_W(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2), .tank_level_status(tank2),
    .column_select(cs2), .rows_status(rows2), .level_displayed(lvl2), .empty_alarm(alarm2)
  );

  typedef struct { int at; logic [1:0] lvl; } lvl_vec_t;
  typedef struct { logic [1:0] lvl; int col; logic [6:0] rows; } img_vec_t;

  lvl_vec_t pv [6];
  img_vec_t iv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_level(input logic [1:0] v, input string name);
    int k;
    k = 0;
    while (lvl !== v && k < 200) begin
      step();
      k++;
    end
    check(name, lvl, v);
  endtask

  task automatic enter_col(input int col, input string name);
    logic [4:0] prev, want;
    bit ok;
    want = 5'b00001 << col;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      prev = cs;
      step();
      if (cs == want && prev != want) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  task automatic enter_col2(input int col, input string name);
    logic [5:0] prev, want;
    bit ok;
    want = 6'b000001 << col;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      prev = cs2;
      step();
      if (cs2 == want && prev != want) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_n, bad, vis, imgbad, blank_viol, k;
    logic [1:0] prev_l, max_l;
    logic [2:0] k2;

    pv = '{'{7, 2'd0}, '{8, 2'd1}, '{15, 2'd1}, '{16, 2'd2}, '{24, 2'd3}, '{40, 2'd3}};
    iv = '{'{2'd3, 0, 7'h7F}, '{2'd3, 2, 7'h7F}, '{2'd3, 4, 7'h7F},
           '{2'd1, 1, 7'h70}, '{2'd1, 3, 7'h70}, '{2'd1, 0, 7'h7F},
           '{2'd2, 2, 7'h7C}, '{2'd2, 4, 7'h7F}};

    // Reset state
    reset_n = 1'b0; enable = 1'b1; tank = 2'd3; enable2 = 1'b1; tank2 = 3'd7;
    #12;
    check("reset_cs", cs, 5'b00001);
    check("reset_rows", rows, 7'h00);
    check("reset_level", lvl, 2'd0);
    check("reset_alarm", alarm, 1'b0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    cyc = 0;

    // Power-on animation 0 -> 3, one step every 8 cycles
    while (cyc < 3) step();
    check("poweron_alarm_clear", alarm, 1'b0);
    for (int i = 0; i < 6; i++) begin
      while (cyc < pv[i].at) step();
      check($sformatf("poweron_level_at_%0d", pv[i].at), lvl, pv[i].lvl);
    end

    // Image table: blank first slot, then column image
    for (int i = 0; i < 8; i++) begin
      tank = iv[i].lvl;
      wait_level(iv[i].lvl, $sformatf("img%0d_level", i));
      enter_col(iv[i].col, $sformatf("img%0d_enter", i));
      check($sformatf("img%0d_blank", i), rows, 7'h00);
      step();
      check($sformatf("img%0d_rows", i), rows, iv[i].rows);
    end

    // Column 4 wraps to column 0 after 4 cycles
    enter_col(4, "wrap_enter");
    step(); step(); step();
    check("wrap_hold_col4", cs, 5'b10000);
    step();
    check("wrap_col0", cs, 5'b00001);
    check("wrap_blank", rows, 7'h00);

    // Drain 3 -> 0, then alarm and blink
    tank = 2'd3;
    wait_level(2'd3, "drain_start");
    tank = 2'd0;
    seq_n = 0; bad = 0; k = 0;
    while (lvl != 2'd0 && k < 100) begin
      prev_l = lvl;
      step();
      k++;
      if (lvl != prev_l) begin
        seq_n++;
        if ((cyc % 8) != 0 || lvl != prev_l - 2'd1) bad++;
      end
    end
    check("drain_steps", seq_n, 3);
    check("drain_step_timing", bad, 0);
    check("alarm_same_cycle", alarm, 1'b0);
    step();
    check("alarm_rises", alarm, 1'b1);
    blank_viol = 0; vis = 0; imgbad = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if ((((cyc - 1) / 16) % 2) == 1) begin
        if (rows != 7'h00) blank_viol++;
      end else if (rows != 7'h00) begin
        vis++;
        if (cs[0] || cs[4]) begin
          if (rows != 7'h7F) imgbad++;
        end else if (rows != 7'h40) imgbad++;
      end
    end
    check("blink_blank", blank_viol, 0);
    check("blink_visible", vis > 0, 1);
    check("empty_image", imgbad, 0);
    check("alarm_held", alarm, 1'b1);
    tank = 2'd2;
    wait_level(2'd2, "refill_level");
    check("refill_alarm_clear", alarm, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("refill_hold", lvl, 2'd2);

    // Target drops to 1 while climbing: no overshoot
    tank = 2'd0;
    wait_level(2'd0, "retarget_zero");
    tank = 2'd3;
    wait_level(2'd1, "retarget_at1");
    tank = 2'd1;
    max_l = lvl;
    for (int i = 0; i < 40; i++) begin
      step();
      if (lvl > max_l) max_l = lvl;
    end
    check("retarget_max", max_l, 2'd1);
    check("retarget_final", lvl, 2'd1);

    // enable dropped mid column 2, then re-enabled
    enter_col(2, "en_enter_col2");
    step();
    enable = 1'b0;
    step();
    check("dis_cs", cs, 5'b00000);
    check("dis_rows", rows, 7'h00);
    for (int i = 0; i < 5; i++) step();
    check("dis_cs_hold", cs, 5'b00000);
    enable = 1'b1;
    step();
    check("reen_cs", cs, 5'b00001);
    check("reen_blank", rows, 7'h00);
    step();
    check("reen_rows", rows, 7'h7F);
    step(); step();
    check("reen_col0_held", cs, 5'b00001);
    step();
    check("reen_col1", cs, 5'b00010);
    check("reen_col1_blank", rows, 7'h00);

    // Asynchronous reset away from the clock edge
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_cs", cs, 5'b00001);
    check("areset_rows", rows, 7'h00);
    check("areset_level", lvl, 2'd0);
    check("areset_alarm", alarm, 1'b0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    cyc = 0;

    // Second configuration: ROWS=8, COLS=6, LEVEL_W=3
    tank2 = 3'd7;
    k = 0;
    while (lvl2 != 3'd7 && k < 200) begin step(); k++; end
    check("cfg2_level7", lvl2, 3'd7);
    enter_col2(2, "cfg2_enter2");
    check("cfg2_blank", rows2, 8'h00);
    step();
    check("cfg2_interior_full", rows2, 8'hFF);
    enter_col2(5, "cfg2_enter5");
    step();
    check("cfg2_wall", rows2, 8'hFF);
    tank2 = 3'd3;
    k = 0;
    while (lvl2 != 3'd3 && k < 200) begin step(); k++; end
    k2 = lvl2;
    check("cfg2_level3", k2, 3'd3);
    enter_col2(1, "cfg2_enter1");
    step();
    check("cfg2_interior_l3", rows2, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
